// File: rtl/shift_pkg.sv
// Shared constants and types for the shift execute front end.
package shift_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned RD_W    = 5;

  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd;
    logic            illegal;
  } shift_entry_t;

endpackage

// File: rtl/shifter.sv
// Combinational 32-bit barrel shifter: logical left, logical right, arithmetic right.
module shifter
  import shift_pkg::*;
(
  input  logic [XLEN-1:0]    shift_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               is_right,
  input  logic               is_right_arith,
  output logic [XLEN-1:0]    shift_out_c
);

  // Select shift direction and fill bit.
  always_comb begin
    shift_out_c = shift_in << shamt;
    if (is_right) begin
      if (is_right_arith) begin
        shift_out_c = XLEN'($signed(shift_in) >>> shamt);
      end else begin
        shift_out_c = shift_in >> shamt;
      end
    end
  end

endmodule

// File: rtl/shift_exec.sv
// Shift execute front end: decode, shifter, 2-entry skid buffer toward writeback.
module shift_exec
  import shift_pkg::*;
#(
  parameter int unsigned REG_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_is_imm,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [XLEN-1:0]          in_rs1,
  input  logic [XLEN-1:0]          in_rs2,
  input  logic [REG_ADDR_BITS-1:0] in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_result,
  output logic [REG_ADDR_BITS-1:0] out_rd,
  output logic                     out_illegal
);

  skid_state_t  state_q, state_d;
  shift_entry_t main_q, main_d;
  shift_entry_t skid_q, skid_d;
  shift_entry_t new_entry_c;

  logic            is_sll_c, is_srl_c, is_sra_c;
  logic [XLEN-1:0] shift_out_c;
  logic            in_fire_c, out_fire_c;

  // OP and OP-IMM decode identically; upper rs2/immediate bits never affect the shift.
  logic unused_c;
  assign unused_c = in_is_imm ^ (^in_rs2[XLEN-1:SHAMT_W]);

  // Legal shift encodings; any other funct3/funct7 pair (incl. shamt[5]) is illegal.
  always_comb begin
    is_sll_c = (in_funct3 == F3_SLL) && (in_funct7 == F7_ZERO);
    is_srl_c = (in_funct3 == F3_SR)  && (in_funct7 == F7_ZERO);
    is_sra_c = (in_funct3 == F3_SR)  && (in_funct7 == F7_SRA);
  end

  shifter u_shifter (
    .shift_in       (in_rs1),
    .shamt          (in_rs2[SHAMT_W-1:0]),
    .is_right       (in_funct3 == F3_SR),
    .is_right_arith (is_sra_c),
    .shift_out_c    (shift_out_c)
  );

  // Build the entry captured on an input transfer.
  always_comb begin
    new_entry_c.illegal = !(is_sll_c || is_srl_c || is_sra_c);
    new_entry_c.result  = new_entry_c.illegal ? '0 : shift_out_c;
    new_entry_c.rd      = RD_W'(in_rd);
  end

  // Handshake: ready depends only on state and reset, never on out_ready.
  always_comb begin
    in_ready   = (state_q != FULL) && reset_n;
    out_valid  = (state_q != EMPTY);
    in_fire_c  = in_valid && in_ready;
    out_fire_c = out_valid && out_ready;
  end

  // Skid buffer next-state: main register drives outputs, skid absorbs one stalled entry.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire_c) begin
          main_d  = new_entry_c;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_d = new_entry_c;
        end else if (in_fire_c) begin
          skid_d  = new_entry_c;
          state_d = FULL;
        end else if (out_fire_c) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire_c) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and payload registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Output payload straight from the main register.
  always_comb begin
    out_result  = main_q.result;
    out_rd      = REG_ADDR_BITS'(main_q.rd);
    out_illegal = main_q.illegal;
  end

endmodule

// File: tb/tb_shift_exec.sv
// Self-checking bench for shift_exec with directed scenarios and a queue-based reference model.
module tb_shift_exec;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_is_imm;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t model_q[$];

  shift_exec #(.REG_ADDR_BITS(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_imm(in_is_imm),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Reference: RV32I shift semantics from the instruction fields.
  function automatic exp_t ref_model(input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [4:0] rd);
    exp_t e;
    int   amt;
    amt   = int'(rs2 % 32);
    e.rd  = rd;
    e.ill = 1'b0;
    if (f3 == 3'd1 && f7 == 7'd0)       e.res = rs1 << amt;
    else if (f3 == 3'd5 && f7 == 7'd0)  e.res = rs1 >> amt;
    else if (f3 == 3'd5 && f7 == 7'h20) e.res = $unsigned($signed(rs1) >>> amt);
    else begin
      e.res = 32'd0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic set_in(input logic v, input logic imm, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [4:0] rd);
    in_valid  = v;
    in_is_imm = imm;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%h rd=%0d ill=%b expected all 0",
               out_valid, out_result, out_rd, out_illegal);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_sll();
    @(negedge clk);
    out_ready = 1'b1;
    set_in(1'b1, 1'b0, 3'b001, 7'd0, 32'h1, 32'h24, 5'd7);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h10 || out_illegal !== 1'b0 || out_rd !== 5'd7) begin
      errors++;
      $display("FAIL sll: got v=%b r=%h ill=%b rd=%0d expected v=1 r=00000010 ill=0 rd=7",
               out_valid, out_result, out_illegal, out_rd);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL sll_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_imm();
    @(negedge clk);
    out_ready = 1'b1;
    set_in(1'b1, 1'b1, 3'b101, 7'h20, 32'h8000_0000, 32'h403, 5'd3);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b1, 1'b1, 3'b101, 7'h00, 32'h8000_0000, 32'h003, 5'd4);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hF000_0000 || out_illegal !== 1'b0 || out_rd !== 5'd3) begin
      errors++;
      $display("FAIL srai: got v=%b r=%h ill=%b rd=%0d expected v=1 r=f0000000 ill=0 rd=3",
               out_valid, out_result, out_illegal, out_rd);
    end
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h1000_0000 || out_illegal !== 1'b0 || out_rd !== 5'd4) begin
      errors++;
      $display("FAIL srli: got v=%b r=%h ill=%b rd=%0d expected v=1 r=10000000 ill=0 rd=4",
               out_valid, out_result, out_illegal, out_rd);
    end
    @(posedge clk);
  endtask

  task automatic test_illegal();
    @(negedge clk);
    out_ready = 1'b1;
    set_in(1'b1, 1'b1, 3'b101, 7'b0000001, 32'hFFFF_FFFF, 32'h021, 5'd9);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'b000, 7'd0, 32'h1234_5678, 32'h1, 5'd10);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd0 || out_illegal !== 1'b1 || out_rd !== 5'd9) begin
      errors++;
      $display("FAIL illegal_shamt5: got v=%b r=%h ill=%b rd=%0d expected v=1 r=0 ill=1 rd=9",
               out_valid, out_result, out_illegal, out_rd);
    end
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd0 || out_illegal !== 1'b1 || out_rd !== 5'd10) begin
      errors++;
      $display("FAIL illegal_f3: got v=%b r=%h ill=%b rd=%0d expected v=1 r=0 ill=1 rd=10",
               out_valid, out_result, out_illegal, out_rd);
    end
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 3'b001, 7'd0, 32'h3, 32'h1, 5'd1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_one: got %b expected 1", in_ready);
    end
    set_in(1'b1, 1'b0, 3'b001, 7'd0, 32'h3, 32'h2, 5'd2);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd1 || out_result !== 32'h6) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b v=%b rd=%0d r=%h expected rdy=0 v=1 rd=1 r=00000006",
               in_ready, out_valid, out_rd, out_result);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_rd !== 5'd1 || out_result !== 32'h6) begin
      errors++; $display("FAIL bp_hold: got rd=%0d r=%h expected rd=1 r=00000006", out_rd, out_result);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_rd !== 5'd2 || out_result !== 32'hC) begin
      errors++;
      $display("FAIL bp_second: got rdy=%b v=%b rd=%0d r=%h expected rdy=1 v=1 rd=2 r=0000000c",
               in_ready, out_valid, out_rd, out_result);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_stream();
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== (32'd1 << (i - 1))) begin
          errors++;
          $display("FAIL stream_%0d: got v=%b r=%h expected v=1 r=%h", i - 1, out_valid, out_result,
                   32'd1 << (i - 1));
        end
      end
      set_in(1'b1, 1'b0, 3'b001, 7'd0, 32'h1, 32'(i), 5'(i));
      @(posedge clk);
      @(negedge clk);
    end
    set_in(1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd128) begin
      errors++; $display("FAIL stream_7: got v=%b r=%h expected v=1 r=00000080", out_valid, out_result);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_full();
    @(negedge clk);
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 3'b001, 7'd0, 32'h5, 32'h2, 5'd11);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'b001, 7'd0, 32'h5, 32'h3, 5'd12);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0);
    reset_n   = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_full_ready: got %b expected 0", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL rst_full_outputs: got v=%b r=%h rd=%0d ill=%b expected all 0",
               out_valid, out_result, out_rd, out_illegal);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_full_stale: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd;
    logic        v, in_fire, out_fire;
    exp_t        e, h;
    model_q.delete();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      case ($urandom_range(3))
        0: f3 = 3'b001;
        1, 2: f3 = 3'b101;
        default: f3 = 3'($urandom);
      endcase
      case ($urandom_range(4))
        0, 1: f7 = 7'h00;
        2, 3: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      rs1 = $urandom;
      rs2 = $urandom;
      rd  = 5'($urandom);
      v   = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      set_in(v, 1'($urandom), f3, f7, rs1, rs2, rd);
      #1;
      checks++;
      if (out_valid !== (model_q.size() != 0) || in_ready !== (model_q.size() < 2)) begin
        errors++;
        $display("FAIL rand_hs_%0d: got v=%b rdy=%b expected v=%b rdy=%b", n, out_valid, in_ready,
                 model_q.size() != 0, model_q.size() < 2);
      end
      if (model_q.size() != 0) begin
        h = model_q[0];
        checks++;
        if (out_result !== h.res || out_rd !== h.rd || out_illegal !== h.ill) begin
          errors++;
          $display("FAIL rand_data_%0d: got r=%h rd=%0d ill=%b expected r=%h rd=%0d ill=%b",
                   n, out_result, out_rd, out_illegal, h.res, h.rd, h.ill);
        end
      end
      in_fire  = v && (model_q.size() < 2);
      out_fire = out_ready && (model_q.size() != 0);
      e = ref_model(f3, f7, rs1, rs2, rd);
      @(posedge clk);
      if (out_fire) void'(model_q.pop_front());
      if (in_fire) model_q.push_back(e);
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    model_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_sll();
    test_imm();
    test_illegal();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
